// File: rtl/rv32_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rv32_regfile_sb                                                   |
// | Brief  : RV32 integer register file with per-register busy scoreboard,     |
// |          two bypassed read ports, two write ports, allocate and flush.     |
// |          Optional even-parity protection when RF_PARITY_EN is defined.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rv32_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [XLEN-1:0]  rd_data_a,
    output logic             rd_rdy_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [XLEN-1:0]  rd_data_b,
    output logic             rd_rdy_b,
    input  logic             wr_en0,
    input  logic [AW-1:0]    wr_addr0,
    input  logic [XLEN-1:0]  wr_data0,
    input  logic             wr_en1,
    input  logic [AW-1:0]    wr_addr1,
    input  logic [XLEN-1:0]  wr_data1,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
`ifdef RF_PARITY_EN
    ,
    output logic             par_err_a,
    output logic             par_err_b
`endif
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
`ifdef RF_PARITY_EN
    logic [NREGS-1:0] par_q;
    logic [NREGS-1:0] par_d;
`endif

    logic w_wr_ok0;
    logic w_wr_ok1;
    logic w_alloc_ok;

    // Register 0 and addresses beyond the array are never stored or tracked.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    assign w_wr_ok0   = wr_en0 && addr_valid(wr_addr0);
    assign w_wr_ok1   = wr_en1 && addr_valid(wr_addr1);
    assign w_alloc_ok = alloc_en && addr_valid(alloc_addr);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
`ifdef RF_PARITY_EN
        par_d  = par_q;
`endif
        for (int i = 1; i < NREGS; i++) begin
            if (w_wr_ok0 && wr_addr0 == AW'(i)) begin
                mem_d[i]  = wr_data0;
                busy_d[i] = 1'b0;
`ifdef RF_PARITY_EN
                par_d[i]  = ^wr_data0;
`endif
            end
            if (w_wr_ok1 && wr_addr1 == AW'(i)) begin
                mem_d[i]  = wr_data1;
                busy_d[i] = 1'b0;
`ifdef RF_PARITY_EN
                par_d[i]  = ^wr_data1;
`endif
            end
            // A fresh allocation supersedes any write-back of the older producer.
            if (w_alloc_ok && alloc_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
        mem_d[0]  = '0;
`ifdef RF_PARITY_EN
        par_d[0]  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
`ifdef RF_PARITY_EN
            par_q  <= '0;
`endif
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
`ifdef RF_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    assign busy_vec = busy_q;

    logic [AW-1:0]   w_rd_addr [2];
    logic [XLEN-1:0] w_rd_data [2];
    logic [1:0]      w_rd_rdy;
`ifdef RF_PARITY_EN
    logic [1:0]      w_par_err;
`endif

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic            w_valid;
        logic            w_hit0;
        logic            w_hit1;
        logic            w_arr_busy;
        logic [XLEN-1:0] w_arr_word;
`ifdef RF_PARITY_EN
        logic            w_arr_par;
`endif

        always_comb begin
            w_arr_word = '0;
            w_arr_busy = 1'b0;
`ifdef RF_PARITY_EN
            w_arr_par  = 1'b0;
`endif
            for (int i = 1; i < NREGS; i++) begin
                if (w_rd_addr[p] == AW'(i)) begin
                    w_arr_word = mem_q[i];
                    w_arr_busy = busy_q[i];
`ifdef RF_PARITY_EN
                    w_arr_par  = par_q[i];
`endif
                end
            end
        end

        assign w_valid = addr_valid(w_rd_addr[p]);
        assign w_hit1  = BYPASS && w_valid && wr_en1 && (wr_addr1 == w_rd_addr[p]);
        assign w_hit0  = BYPASS && w_valid && wr_en0 && (wr_addr0 == w_rd_addr[p]);

        assign w_rd_data[p] = !w_valid ? '0       :
                              w_hit1   ? wr_data1 :
                              w_hit0   ? wr_data0 : w_arr_word;
        assign w_rd_rdy[p]  = !w_valid || !w_arr_busy || w_hit0 || w_hit1;
`ifdef RF_PARITY_EN
        assign w_par_err[p] = w_valid && !w_hit0 && !w_hit1 && ((^w_arr_word) != w_arr_par);
`endif
    end

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign rd_rdy_a  = w_rd_rdy[0];
    assign rd_rdy_b  = w_rd_rdy[1];
`ifdef RF_PARITY_EN
    assign par_err_a = w_par_err[0];
    assign par_err_b = w_par_err[1];
`endif

endmodule
`default_nettype wire

// File: doc/rv32_regfile_sb.md
Name: rv32_regfile_sb

Overview:
- Parametrised integer register file with a per-register scoreboard.
- Two combinational read ports with write-to-read bypass, two write-back ports, one allocate port and a flush.
- Sits between decode/issue and write-back of the next-generation RV32 core.
- Issue stalls on the per-read-port ready flags instead of external hazard logic.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (2..32). Register 0 is hardwired zero.
- BYPASS, 1, 1 = write-port data forwarded to read ports in the same cycle; 0 = reads see array contents only.
- AW (localparam), clog2(NREGS), address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a  in  AW  read port A address
- rd_data_a  out  XLEN  read port A data
- rd_rdy_a  out  1  read port A operand valid (not pending)
- rd_addr_b  in  AW  read port B address
- rd_data_b  out  XLEN  read port B data
- rd_rdy_b  out  1  read port B operand valid
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  AW  write port 0 address
- wr_data0  in  XLEN  write port 0 data
- wr_en1  in  1  write port 1 enable
- wr_addr1  in  AW  write port 1 address
- wr_data1  in  XLEN  write port 1 data
- alloc_en  in  1  mark alloc_addr busy (instruction issued with destination)
- alloc_addr  in  AW  destination being allocated
- flush  in  1  clear all busy bits
- busy_vec  out  NREGS  current scoreboard state, bit i = register i pending

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0. rd_data_x then reads 0 and rd_rdy_x = 1. Takes effect mid-operation; pending allocations are lost.
- Writes commit at posedge clk when wr_enN=1 and wr_addrN!=0.
  - Writes to address 0 or to address >= NREGS are ignored.
  - Both ports same address in the same cycle: port 1 wins.
- Reads are combinational (zero latency). Address 0 or >= NREGS returns 0 with rdy=1.
- BYPASS=1 read priority: wr_en1 hit > wr_en0 hit > array. Hit = wr_enN and wr_addrN == rd_addr and rd_addr != 0.
- BYPASS=0: array only. A value written at edge k is readable after edge k.
- rd_rdy_x = (addr==0) | !busy[addr] | (BYPASS & bypass hit).
- Scoreboard update per posedge, for registers 1..NREGS-1:
  - clear bit wr_addrN for each active write port;
  - set bit alloc_addr when alloc_en and alloc_addr != 0;
  - set beats clear for the same register in the same cycle, since the new producer supersedes;
  - flush=1: busy_vec <= 0, overriding alloc_en in that cycle. Writes in a flush cycle still commit to the array.
- Allocating a register that is already busy keeps it busy. There is no count; the youngest producer owns it.
- Busy bit 0 is always 0.

Optional Feature:
- Macro RF_PARITY_EN.
- Defined:
  - each entry stores an even-parity bit computed from write data;
  - adds outputs par_err_a and par_err_b (1 bit each), combinational, =1 when the array-sourced read word mismatches its stored parity;
  - par_err is 0 for bypassed reads, register 0 and out-of-range addresses;
  - reset parity bits = 0 (consistent with zero data).
- Not defined: no parity storage, no par_err ports; behaviour otherwise identical.

Test Plan:
- Reset then read all addresses on A and B -> rd_data=0, rd_rdy=1, busy_vec=0.
- wr_en0 addr5 data 0xDEADBEEF, next cycle read A=5 -> 0xDEADBEEF. Same-cycle read with BYPASS=1 -> 0xDEADBEEF, rdy=1.
- alloc addr7 at cycle 0, read A=7 at cycle 1 -> rd_rdy_a=0, busy_vec[7]=1. wr_en1 addr7 data 0x12 at cycle 3 -> same-cycle rdy=1, data 0x12; busy_vec[7]=0 after the edge.
- Same cycle: alloc addr9 and wr_en0 addr9 -> busy_vec[9]=1 after the edge. Both write ports to addr3 (0x1, 0x2) -> reg3=0x2.
- Write addr0 data 0xFFFFFFFF, alloc addr0 -> read 0 gives 0, busy_vec[0]=0. alloc addr4 with flush=1 -> busy_vec=0.
- alloc addr6, then assert rst_n=0 mid-cycle -> busy_vec and reg6 read 0 immediately. RF_PARITY_EN: force a stored bit flip on reg2 -> par_err_a=1 on read A=2.
